// File: rtl/demo_slave_responder_pkg.sv
// Shared constants and types for the demo-bus slave responder:
// request mode encoding, FSM state encodings and the latched request flags.
`timescale 1ns/1ps
package demo_slave_responder_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int WAIT_CNT_WIDTH = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_ACCESS = 3'd2;
    localparam state_t ST_RDATA  = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    typedef struct packed {
        logic mode;
        logic in_range;
    } req_flags_t;

endpackage

// File: rtl/demo_slave_responder_if.sv
// Request/response handshake between a demo-bus slave port and its device-side
// responder; the responder takes the slave modport.
`timescale 1ns/1ps
interface demo_slave_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) ();

    logic                  req_valid;
    logic                  req_mode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_mode, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_mode, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/demo_slave_responder_bram.sv
// Inferred single-port synchronous RAM with one-cycle read latency; port names
// follow the vendor BRAM macro so it can be swapped in directly.
`timescale 1ns/1ps
module slave_bram_sp
    import demo_slave_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/demo_slave_responder.sv
// Device-side responder: services one demo-bus request at a time from a local
// single-port RAM, with optional wait states and completed-transaction counters.
`timescale 1ns/1ps
module demo_slave_responder
    import demo_slave_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MEM_ADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h1000,
    parameter int                    WAIT_CYCLES    = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 'hEE,
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    demo_slave_responder_if.slave bus,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    state_t                    state_q, state_d;
    req_flags_t                flags_q, flags_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

    logic [ADDR_WIDTH-1:0]     req_offset;
    logic                      req_in_range;
    logic                      mem_wren;
    logic [DATA_WIDTH-1:0]     mem_q;

    // Once the address is at or above the base, the offset cannot wrap, so a
    // zero upper slice means it falls inside the memory window.
    assign req_offset   = bus.req_addr - BASE_ADDR;
    assign req_in_range = (bus.req_addr >= BASE_ADDR) &&
                          (req_offset[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0);

    assign mem_wren = (state_q == ST_ACCESS) && flags_q.in_range &&
                      (flags_q.mode == MODE_WRITE);

    slave_bram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_bram (
        .clock   (clk),
        .address (idx_q),
        .data    (wdata_q),
        .wren    (mem_wren),
        .q       (mem_q)
    );

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    flags_d.mode     = bus.req_mode;
                    flags_d.in_range = req_in_range;
                    idx_d            = req_offset[MEM_ADDR_WIDTH-1:0];
                    wdata_d          = bus.req_wdata;
                    wait_cnt_d       = WAIT_LOAD;
                    state_d          = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_WIDTH'(1);
                end
            end
            ST_ACCESS: begin
                if (!flags_q.in_range) begin
                    if (flags_q.mode == MODE_READ) begin
                        rdata_d = ERR_DATA;
                    end
                    state_d = ST_RESP;
                end else if (flags_q.mode == MODE_WRITE) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rdata_d = mem_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!flags_q.in_range) begin
                    err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                end else if (flags_q.mode == MODE_WRITE) begin
                    wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            flags_q    <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = (state_q == ST_RESP) && !flags_q.in_range;
    assign bus.rsp_rdata = rdata_q;

    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_demo_slave_responder.sv
// Bench for demo_slave_responder: two instances (no wait states / 16-bit
// counters, and three wait states / 2-bit counters) checked against a
// transaction-level model every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_demo_slave_responder;

    localparam int W_A = 0;
    localparam int W_B = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    demo_slave_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_a ();
    demo_slave_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_b ();

    logic [15:0] wr_a, rd_a, err_a;
    logic [1:0]  wr_b, rd_b, err_b;

    demo_slave_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(5), .BASE_ADDR(16'h1000),
        .WAIT_CYCLES(W_A), .ERR_DATA(8'hEE), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a),
        .wr_count(wr_a), .rd_count(rd_a), .err_count(err_a)
    );

    demo_slave_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(5), .BASE_ADDR(16'h1000),
        .WAIT_CYCLES(W_B), .ERR_DATA(8'hEE), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b),
        .wr_count(wr_b), .rd_count(rd_b), .err_count(err_b)
    );

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic cmp_en = 1'b0;

    // Transaction-level model: a pending request, the edge its response is
    // sampled at, the memory image and plain integer counters.
    logic       busy      [2];
    int         resp_edge [2];
    logic       m_mode    [2];
    logic       m_inr     [2];
    logic [4:0] m_idx     [2];
    logic [7:0] m_wd      [2];
    logic [7:0] m_mem     [2][32];
    logic [7:0] m_rdata   [2];
    int         m_wr      [2];
    int         m_rd      [2];
    int         m_err     [2];
    logic [7:0] init_val  [2][32];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=0x%0h expected=0x%0h", name, d, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name, input int d);
        checks++;
        errors++;
        $display("[TB] FAIL %s dut%0d actual=no event within 40 cycles expected=event", name, d);
    endtask

    function automatic logic [31:0] get_out(input int d, input int sel);
        logic [31:0] r;
        r = '0;
        if (d == 0) begin
            case (sel)
                0: r = 32'(bus_a.req_ready);
                1: r = 32'(bus_a.rsp_valid);
                2: r = 32'(bus_a.rsp_err);
                3: r = 32'(bus_a.rsp_rdata);
                4: r = 32'(wr_a);
                5: r = 32'(rd_a);
                default: r = 32'(err_a);
            endcase
        end else begin
            case (sel)
                0: r = 32'(bus_b.req_ready);
                1: r = 32'(bus_b.rsp_valid);
                2: r = 32'(bus_b.rsp_err);
                3: r = 32'(bus_b.rsp_rdata);
                4: r = 32'(wr_b);
                5: r = 32'(rd_b);
                default: r = 32'(err_b);
            endcase
        end
        return r;
    endfunction

    task automatic set_req(input int d, input logic v, input logic m, input logic [15:0] a, input logic [7:0] wd);
        if (d == 0) begin
            bus_a.req_valid = v; bus_a.req_mode = m; bus_a.req_addr = a; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_mode = m; bus_b.req_addr = a; bus_b.req_wdata = wd;
        end
    endtask

    task automatic model_step(input int d, input int w, input logic v, input logic m,
                              input logic [15:0] a, input logic [7:0] wd);
        if (!rstn) begin
            busy[d]    = 1'b0;
            m_rdata[d] = 8'h00;
            m_wr[d]    = 0;
            m_rd[d]    = 0;
            m_err[d]   = 0;
        end else if (!busy[d]) begin
            if (v === 1'b1) begin
                busy[d]      = 1'b1;
                m_mode[d]    = m;
                m_inr[d]     = (a >= 16'h1000) && (a < 16'h1020);
                m_idx[d]     = 5'(a - 16'h1000);
                m_wd[d]      = wd;
                resp_edge[d] = edge_n + 2 + w + ((m == 1'b0 && m_inr[d]) ? 1 : 0);
            end
        end else begin
            if (edge_n == resp_edge[d] - 1) begin
                if (m_inr[d] && m_mode[d]) m_mem[d][m_idx[d]] = m_wd[d];
                else if (!m_mode[d]) m_rdata[d] = m_inr[d] ? m_mem[d][m_idx[d]] : 8'hEE;
            end
            if (edge_n == resp_edge[d]) begin
                busy[d] = 1'b0;
                if (!m_inr[d]) m_err[d]++;
                else if (m_mode[d]) m_wr[d]++;
                else m_rd[d]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        model_step(0, W_A, bus_a.req_valid, bus_a.req_mode, bus_a.req_addr, bus_a.req_wdata);
        model_step(1, W_B, bus_b.req_valid, bus_b.req_mode, bus_b.req_addr, bus_b.req_wdata);
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en && rstn) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] mask;
                logic        ev;
                mask = (d == 0) ? 32'hFFFF : 32'h3;
                ev   = busy[d] && (edge_n + 1 == resp_edge[d]);
                check("req_ready", d, get_out(d, 0), 32'(!busy[d]));
                check("rsp_valid", d, get_out(d, 1), 32'(ev));
                check("rsp_err", d, get_out(d, 2), 32'(ev && !m_inr[d]));
                check("rsp_rdata", d, get_out(d, 3), 32'(m_rdata[d]));
                check("wr_count", d, get_out(d, 4), m_wr[d] & mask);
                check("rd_count", d, get_out(d, 5), m_rd[d] & mask);
                check("err_count", d, get_out(d, 6), m_err[d] & mask);
            end
        end
    end

    task automatic wait_idle(input int d);
        for (int k = 0; k < 40 && busy[d]; k++) @(negedge clk);
        if (busy[d]) fail_timeout("idle_wait", d);
    endtask

    // Issue one request at a negedge; with poke, req_valid stays high with other
    // fields for two cycles after acceptance, which must be ignored.
    task automatic apply_stimulus(input int d, input logic mode, input logic [15:0] addr,
                                  input logic [7:0] wd, input logic poke,
                                  output logic [7:0] rdata, output logic err, output int lat);
        int   acc;
        logic seen;
        wait_idle(d);
        set_req(d, 1'b1, mode, addr, wd);
        @(negedge clk);
        acc   = edge_n;
        seen  = 1'b0;
        lat   = 0;
        rdata = 8'h00;
        err   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (get_out(d, 1) == 32'd1) begin
                seen  = 1'b1;
                lat   = edge_n + 1 - acc;
                rdata = 8'(get_out(d, 3));
                err   = get_out(d, 2) != 32'd0;
                break;
            end
            if (poke && k < 2) begin
                set_req(d, 1'b1, ~mode, addr ^ 16'h0005, ~wd);
                check("ready_low_busy", d, get_out(d, 0), 32'd0);
            end else begin
                set_req(d, 1'b0, 1'b0, 16'h0000, 8'h00);
            end
            @(negedge clk);
        end
        set_req(d, 1'b0, 1'b0, 16'h0000, 8'h00);
        if (!seen) fail_timeout("rsp_wait", d);
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input int d, input logic [7:0] rdata,
                                input logic err, input int lat,
                                input logic [7:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input logic chk_rdata);
        check({name, "_lat"}, d, lat, exp_lat);
        check({name, "_err"}, d, 32'(err), 32'(exp_err));
        if (chk_rdata) check({name, "_rdata"}, d, 32'(rdata), 32'(exp_rdata));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rd;
        logic        er;
        int          lat;
        int          d;
        int          sel;
        logic [15:0] a;

        set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) init_val[i][j] = 8'($urandom);
        init_val[1][4] = 8'h3C;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rstn   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, get_out(i, 0), 32'd1);
            check("rst_valid", i, get_out(i, 1), 32'd0);
            check("rst_err", i, get_out(i, 2), 32'd0);
            check("rst_rdata", i, get_out(i, 3), 32'd0);
            check("rst_wr", i, get_out(i, 4), 32'd0);
            check("rst_rd", i, get_out(i, 5), 32'd0);
            check("rst_errcnt", i, get_out(i, 6), 32'd0);
        end

        apply_stimulus(0, 1'b1, 16'h1003, 8'hA5, 1'b0, rd, er, lat);
        check_output("wr1003", 0, rd, er, lat, 8'h00, 1'b0, 2, 1'b0);
        check("wr1003_cnt", 0, get_out(0, 4), 32'd1);
        apply_stimulus(0, 1'b0, 16'h1003, 8'h00, 1'b0, rd, er, lat);
        check_output("rd1003", 0, rd, er, lat, 8'hA5, 1'b0, 3, 1'b1);
        check("rd1003_cnt", 0, get_out(0, 5), 32'd1);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++)
                apply_stimulus(i, 1'b1, 16'h1000 + 16'(j), init_val[i][j], 1'b0, rd, er, lat);

        apply_stimulus(0, 1'b0, 16'h2000, 8'h00, 1'b0, rd, er, lat);
        check_output("rd2000", 0, rd, er, lat, 8'hEE, 1'b1, 2, 1'b1);
        apply_stimulus(0, 1'b1, 16'h0FFF, 8'h77, 1'b0, rd, er, lat);
        check_output("wr0fff", 0, rd, er, lat, 8'h00, 1'b1, 2, 1'b0);
        check("oob_errcnt", 0, get_out(0, 6), 32'd2);
        apply_stimulus(0, 1'b0, 16'h101F, 8'h00, 1'b0, rd, er, lat);
        check_output("rd_idx31", 0, rd, er, lat, init_val[0][31], 1'b0, 3, 1'b1);
        apply_stimulus(0, 1'b0, 16'h1000, 8'h00, 1'b0, rd, er, lat);
        check_output("rd_idx0", 0, rd, er, lat, init_val[0][0], 1'b0, 3, 1'b1);

        apply_stimulus(0, 1'b1, 16'h101F, 8'h5A, 1'b0, rd, er, lat);
        check_output("wr101f", 0, rd, er, lat, 8'h00, 1'b0, 2, 1'b0);
        apply_stimulus(0, 1'b1, 16'h1020, 8'hC3, 1'b0, rd, er, lat);
        check_output("wr1020", 0, rd, er, lat, 8'h00, 1'b1, 2, 1'b0);
        apply_stimulus(0, 1'b0, 16'h101F, 8'h00, 1'b0, rd, er, lat);
        check_output("rd101f", 0, rd, er, lat, 8'h5A, 1'b0, 3, 1'b1);

        apply_stimulus(1, 1'b0, 16'h1007, 8'h00, 1'b1, rd, er, lat);
        check_output("w3_rd", 1, rd, er, lat, init_val[1][7], 1'b0, 6, 1'b1);
        apply_stimulus(1, 1'b1, 16'h1008, 8'h96, 1'b1, rd, er, lat);
        check_output("w3_wr", 1, rd, er, lat, 8'h00, 1'b0, 5, 1'b0);

        // Abort a write to 0x1004 while it is still waiting.
        wait_idle(1);
        set_req(1, 1'b1, 1'b1, 16'h1004, 8'h11);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("abort_no_rsp", 1, get_out(1, 1), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            check("abort_wr", i, get_out(i, 4), 32'd0);
            check("abort_rd", i, get_out(i, 5), 32'd0);
            check("abort_errcnt", i, get_out(i, 6), 32'd0);
        end
        apply_stimulus(1, 1'b0, 16'h1004, 8'h00, 1'b0, rd, er, lat);
        check_output("abort_rd1004", 1, rd, er, lat, 8'h3C, 1'b0, 6, 1'b1);

        for (int i = 0; i < 5; i++)
            apply_stimulus(1, 1'b1, 16'h1008 + 16'(i), 8'(i * 17 + 1), 1'b0, rd, er, lat);
        check("wrap_wr", 1, get_out(1, 4), 32'd1);

        for (int n = 0; n < 300; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 8) a = 16'h1000 + 16'($urandom_range(0, 31));
            else if (sel == 8) a = 16'h0FF8 + 16'($urandom_range(0, 47));
            else a = 16'($urandom);
            apply_stimulus(d, 1'($urandom_range(0, 1)), a, 8'($urandom),
                           1'($urandom_range(0, 1)), rd, er, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
